// File: rtl/semaforo_ctrl.sv
// Two-approach traffic-light controller with minimum green, all-red clearance and night flash.
// Latency: lamps and fase decode the registered state combinationally, so there is no extra output delay.
// Backpressure: none; bt is latched as a pending request and noite overrides every other exit.
//
// Ports:
//   clk      - single clock; all state updates on the rising edge
//   rst      - synchronous active-high reset; has priority over every other input
//   bt       - crossing request, sampled every edge (held high = repeated presses)
//   noite    - night-mode level enable
//   A, B     - road lamps {red,yellow,green}
//   req_pend - latched request waiting to be served
//   fase     - current state code (debug)
module semaforo_ctrl #(
  parameter int CNT_W       = 8,
  parameter int T_VERDE_MIN = 4,
  parameter int T_AMARELO   = 3,
  parameter int T_VERMELHO  = 2,
  parameter int T_VERDE_B   = 5,
  parameter int T_PISCA     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       noite,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       req_pend,
  output logic [2:0] fase
);

  localparam logic [2:0] A_VERDE = 3'd0;
  localparam logic [2:0] A_AMAR  = 3'd1;
  localparam logic [2:0] VERM1   = 3'd2;
  localparam logic [2:0] B_VERDE = 3'd3;
  localparam logic [2:0] B_AMAR  = 3'd4;
  localparam logic [2:0] VERM2   = 3'd5;
  localparam logic [2:0] NOITE   = 3'd6;

  localparam logic [2:0] L_RED   = 3'b100;
  localparam logic [2:0] L_YEL   = 3'b010;
  localparam logic [2:0] L_GRN   = 3'b001;
  localparam logic [2:0] L_DARK  = 3'b000;

  // A zero duration is treated as one cycle, so every limit is max(D,1)-1.
  localparam int D_VMIN  = (T_VERDE_MIN < 1) ? 1 : T_VERDE_MIN;
  localparam int D_AMAR  = (T_AMARELO   < 1) ? 1 : T_AMARELO;
  localparam int D_VERM  = (T_VERMELHO  < 1) ? 1 : T_VERMELHO;
  localparam int D_VB    = (T_VERDE_B   < 1) ? 1 : T_VERDE_B;
  localparam int D_PISCA = (T_PISCA     < 1) ? 1 : T_PISCA;

  localparam logic [CNT_W-1:0] LIM_VMIN  = CNT_W'(D_VMIN - 1);
  localparam logic [CNT_W-1:0] LIM_AMAR  = CNT_W'(D_AMAR - 1);
  localparam logic [CNT_W-1:0] LIM_VERM  = CNT_W'(D_VERM - 1);
  localparam logic [CNT_W-1:0] LIM_VB    = CNT_W'(D_VB - 1);
  localparam logic [CNT_W-1:0] LIM_PISCA = CNT_W'(D_PISCA - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pisca;

  // Next-state selection; night mode overrides timer and request exits.
  always_comb begin
    state_nxt = state;
    case (state)
      A_VERDE: if ((req_pend | bt) && (cnt >= LIM_VMIN)) state_nxt = A_AMAR;
      A_AMAR:  if (cnt == LIM_AMAR) state_nxt = VERM1;
      VERM1:   if (cnt == LIM_VERM) state_nxt = B_VERDE;
      B_VERDE: if (cnt == LIM_VB)   state_nxt = B_AMAR;
      B_AMAR:  if (cnt == LIM_AMAR) state_nxt = VERM2;
      VERM2:   if (cnt == LIM_VERM) state_nxt = A_VERDE;
      NOITE:   if (!noite)          state_nxt = VERM2;
      default:                      state_nxt = A_VERDE;
    endcase
    if (noite) state_nxt = NOITE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= A_VERDE;
      cnt      <= '0;
      req_pend <= 1'b0;
      pisca    <= 1'b0;
    end else begin
      state <= state_nxt;

      // Phase timer. Inside NOITE it doubles as the flash half-period timer,
      // wrapping each time the lamp toggles.
      if (state_nxt != state) begin
        cnt   <= '0;
        pisca <= (state_nxt == NOITE);
      end else if (state == NOITE) begin
        if (cnt >= LIM_PISCA) begin
          cnt   <= '0;
          pisca <= ~pisca;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end

      // Request latch: night mode and B_VERDE entry both clear it and win over bt.
      if ((state == NOITE) || (state_nxt == NOITE)) begin
        req_pend <= 1'b0;
      end else if ((state_nxt == B_VERDE) && (state != B_VERDE)) begin
        req_pend <= 1'b0;
      end else if (bt) begin
        req_pend <= 1'b1;
      end
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    A = L_RED;
    B = L_RED;
    case (state)
      A_VERDE: begin A = L_GRN; B = L_RED; end
      A_AMAR:  begin A = L_YEL; B = L_RED; end
      VERM1:   begin A = L_RED; B = L_RED; end
      B_VERDE: begin A = L_RED; B = L_GRN; end
      B_AMAR:  begin A = L_RED; B = L_YEL; end
      VERM2:   begin A = L_RED; B = L_RED; end
      NOITE:   begin
        A = pisca ? L_YEL : L_DARK;
        B = pisca ? L_YEL : L_DARK;
      end
      default: begin A = L_RED; B = L_RED; end
    endcase
  end

  assign fase = state;

endmodule
